// File: rtl/taylor_pkg.sv
// Shared constants, state encoding and helpers for the Taylor cosine sweep block.
package taylor_pkg;

    localparam int unsigned W        = 18;
    localparam int unsigned FXP_FRAC = 16;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } sweep_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/taylor_sweep_timer.sv
// Loadable down-counter with a zero flag; the sweep controller reuses it for
// the inter-sample gap and for the core-response timeout.
module taylor_sweep_timer #(
    parameter int unsigned CW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_zero_c
);

    logic [CW-1:0] r_count;

    // Load wins over decrement; the count parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/taylor_sweep_ctrl.sv
// Sweeps an angle from STEP to LIMIT through an external Taylor cosine core and
// streams (angle, cos) pairs out. Optional core timeout: SWEEP_TIMEOUT_EN.
module taylor_sweep_ctrl #(
    parameter int unsigned W          = taylor_pkg::W,
    parameter int unsigned STEP       = 64,
    parameter int unsigned LIMIT      = 102891,
    parameter int unsigned GAP_CYCLES = 5,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sweep_go,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          core_start,
    output logic [W-1:0]  core_angle,
    input  logic          core_ready,
    input  logic [W-1:0]  core_cos,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_angle,
    output logic [W-1:0]  res_cos,
    output logic [15:0]   sample_cnt
);

    import taylor_pkg::*;

    localparam int unsigned TMR_MAX  = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int unsigned TMR_W    = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
    localparam int unsigned TO_LOAD  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    sweep_state_t       r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_core_start;
    logic [W-1:0]       r_core_angle;
    logic               r_res_valid;
    logic [W-1:0]       r_res_angle;
    logic [W-1:0]       r_res_cos;
    logic [CNT_W-1:0]   r_sample_cnt;

    logic [W:0]         w_next_angle;
    logic               w_last;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_en;
    logic               w_tmr_zero;

    // One extra bit keeps angle+STEP from wrapping before the limit compare.
    assign w_next_angle = {1'b0, r_core_angle} + (W+1)'(STEP);
    assign w_last       = (w_next_angle > (W+1)'(LIMIT));

    // Timer arms for the timeout on ISSUE and for the gap on the result handshake.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_tmr_en   = 1'b0;
        case (r_state)
            S_ISSUE: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TMR_W'(TO_LOAD);
            end
            S_EMIT: begin
                w_tmr_load = res_ready;
                w_tmr_val  = TMR_W'(GAP_LOAD);
            end
            S_WAIT, S_GAP: begin
                w_tmr_en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    taylor_sweep_timer #(
        .CW (TMR_W)
    ) u_timer (
        .clk        (clock),
        .rst_n      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero_c   (w_tmr_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_start <= 1'b0;
            r_core_angle <= '0;
            r_res_valid  <= 1'b0;
            r_res_angle  <= '0;
            r_res_cos    <= '0;
            r_sample_cnt <= '0;
        end else begin
            r_core_start <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sweep_go) begin
                        r_state      <= S_ISSUE;
                        r_busy       <= 1'b1;
                        r_core_start <= 1'b1;
                        r_core_angle <= W'(STEP);
                        r_sample_cnt <= '0;
                        r_err        <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_ready) begin
                        r_res_cos   <= core_cos;
                        r_res_angle <= r_core_angle;
                        r_res_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end
`ifdef SWEEP_TIMEOUT_EN
                    else if (w_tmr_zero) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
`endif
                end
                S_EMIT: begin
                    if (res_ready) begin
                        r_res_valid  <= 1'b0;
                        r_sample_cnt <= sat_inc(r_sample_cnt);
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_core_angle <= w_next_angle[W-1:0];
                            r_state      <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (w_tmr_zero) begin
                        r_core_start <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign core_start = r_core_start;
    assign core_angle = r_core_angle;
    assign res_valid  = r_res_valid;
    assign res_angle  = r_res_angle;
    assign res_cos    = r_res_cos;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_taylor_sweep_ctrl.sv
// Directed bench for taylor_sweep_ctrl: cycle table for the first sample, then a
// full default sweep against a fixed-latency core model, reset and timeout cases.
`timescale 1ns/1ps
module tb_taylor_sweep_ctrl;

    localparam int unsigned W        = 18;
    localparam int unsigned STEP     = 64;
    localparam int unsigned NRES     = 1607;
    localparam int unsigned LAST_ANG = 102848;
    localparam int unsigned NVEC     = 11;

    typedef struct packed {
        logic         go;
        logic         rdy;
        logic [W-1:0] cos;
        logic         rr;
    } ins_t;

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         start;
        logic [W-1:0] ang;
        logic         rv;
        logic [W-1:0] ra;
        logic [W-1:0] rc;
        logic [15:0]  cnt;
        logic         err;
    } outs_t;

    typedef struct packed {
        ins_t  i;
        outs_t o;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         sweep_go = 1'b0;
    logic         busy, done, err, core_start, res_valid;
    logic [W-1:0] core_angle, res_angle, res_cos;
    logic [15:0]  sample_cnt;
    logic         core_ready;
    logic [W-1:0] core_cos;
    logic         res_ready = 1'b0;

    logic         tb_ready = 1'b0;
    logic [W-1:0] tb_cos = '0;
    logic         mdl_ready = 1'b0;
    logic [W-1:0] mdl_cos = '0;
    logic         model_en = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    assign core_ready = tb_ready | mdl_ready;
    assign core_cos   = mdl_ready ? mdl_cos : tb_cos;

    taylor_sweep_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .sweep_go   (sweep_go),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .core_start (core_start),
        .core_angle (core_angle),
        .core_ready (core_ready),
        .core_cos   (core_cos),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_angle  (res_angle),
        .res_cos    (res_cos),
        .sample_cnt (sample_cnt)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [W-1:0] cos_of(input logic [W-1:0] a);
        return (a ^ 18'h2B4C3) + 18'd7;
    endfunction

    function automatic outs_t get_outs();
        outs_t o;
        o.busy  = busy;
        o.done  = done;
        o.start = core_start;
        o.ang   = core_angle;
        o.rv    = res_valid;
        o.ra    = res_angle;
        o.rc    = res_cos;
        o.cnt   = sample_cnt;
        o.err   = err;
        return o;
    endfunction

    function automatic vec_t mk(input logic go, input logic rdy, input logic [W-1:0] cos,
                                input logic rr, input logic bsy, input logic st,
                                input logic [W-1:0] ang, input logic rv,
                                input logic [W-1:0] ra, input logic [W-1:0] rc,
                                input logic [15:0] cnt);
        vec_t v;
        v.i.go    = go;
        v.i.rdy   = rdy;
        v.i.cos   = cos;
        v.i.rr    = rr;
        v.o.busy  = bsy;
        v.o.done  = 1'b0;
        v.o.start = st;
        v.o.ang   = ang;
        v.o.rv    = rv;
        v.o.ra    = ra;
        v.o.rc    = rc;
        v.o.cnt   = cnt;
        v.o.err   = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Core model: cos_of(angle) 17 cycles after core_start, plus one stray
    // ready pulse in the gap after the third accepted result.
    initial begin : core_model
        int           cnt;
        int           hs;
        bit           spur;
        logic         prev_valid;
        logic [W-1:0] ang;
        cnt = 0; hs = 0; spur = 1'b0; prev_valid = 1'b0; ang = '0;
        forever begin
            @(negedge clock);
            mdl_ready = 1'b0;
            if (!reset || !model_en) begin
                cnt  = 0;
                spur = 1'b0;
            end else begin
                if (prev_valid && !res_valid) begin
                    hs++;
                    if (hs == 3) spur = 1'b1;
                end else if (spur) begin
                    mdl_ready = 1'b1;
                    mdl_cos   = 18'h3FFFF;
                    spur      = 1'b0;
                end
                if (core_start) begin
                    cnt = 17;
                    ang = core_angle;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        mdl_ready = 1'b1;
                        mdl_cos   = cos_of(ang);
                    end
                end
            end
            prev_valid = res_valid;
        end
    end

    initial begin : main
        vec_t         vecs[NVEC];
        logic [W-1:0] exp_angle;
        logic [W-1:0] last_angle;
        int           n_res, n_done, n_start, stall_left;
        bit           stalled, finished, seen;

        // First sample of a sweep, cycle by cycle: stall, stray ready in GAP, go in GAP.
        vecs[0]  = mk(1, 0, 18'h0,     0, 1, 1, 18'd64,  0, 18'd0,  18'h0,     16'd0);
        vecs[1]  = mk(0, 0, 18'h0,     0, 1, 0, 18'd64,  0, 18'd0,  18'h0,     16'd0);
        vecs[2]  = mk(0, 1, 18'h12345, 0, 1, 0, 18'd64,  1, 18'd64, 18'h12345, 16'd0);
        vecs[3]  = mk(0, 0, 18'h0,     0, 1, 0, 18'd64,  1, 18'd64, 18'h12345, 16'd0);
        vecs[4]  = mk(0, 0, 18'h0,     1, 1, 0, 18'd128, 0, 18'd64, 18'h12345, 16'd1);
        vecs[5]  = mk(0, 1, 18'h3FFFF, 0, 1, 0, 18'd128, 0, 18'd64, 18'h12345, 16'd1);
        vecs[6]  = mk(0, 0, 18'h0,     0, 1, 0, 18'd128, 0, 18'd64, 18'h12345, 16'd1);
        vecs[7]  = mk(1, 0, 18'h0,     0, 1, 0, 18'd128, 0, 18'd64, 18'h12345, 16'd1);
        vecs[8]  = mk(0, 0, 18'h0,     0, 1, 0, 18'd128, 0, 18'd64, 18'h12345, 16'd1);
        vecs[9]  = mk(0, 0, 18'h0,     0, 1, 1, 18'd128, 0, 18'd64, 18'h12345, 16'd1);
        vecs[10] = mk(0, 0, 18'h0,     0, 1, 0, 18'd128, 0, 18'd64, 18'h12345, 16'd1);

        #1 reset = 1'b0;
        #10 chk("reset_state", 128'(get_outs()), 128'(0));
        @(negedge clock) reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < int'(NVEC); i++) begin
            sweep_go  = vecs[i].i.go;
            tb_ready  = vecs[i].i.rdy;
            tb_cos    = vecs[i].i.cos;
            res_ready = vecs[i].i.rr;
            @(negedge clock);
            chk($sformatf("vec%0d", i), 128'(get_outs()), 128'(vecs[i].o));
        end
        sweep_go = 1'b0; tb_ready = 1'b0; tb_cos = '0; res_ready = 1'b0;

        // Asynchronous reset in WAIT clears everything without a clock edge.
        #2 reset = 1'b0;
        #1 chk("reset_in_wait", 128'(get_outs()), 128'(0));
        @(negedge clock) reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (core_start || busy) seen = 1'b1;
        end
        chk("idle_after_reset", 128'(seen), 128'(0));

        // Full default sweep with a 10-cycle output stall and ignored sweep_go pulses.
        model_en = 1'b1;
        exp_angle = 18'(STEP); last_angle = '0;
        n_res = 0; n_done = 0; n_start = 0; stall_left = 0;
        stalled = 1'b0; finished = 1'b0;
        res_ready = 1'b1;
        sweep_go  = 1'b1;
        for (int cyc = 0; cyc < 45000 && !finished; cyc++) begin
            @(negedge clock);
            sweep_go = 1'b0;
            if (core_start) n_start++;
            if (done) n_done++;
            if ((n_res == 2 && res_valid) || (n_res == 4 && core_start)) sweep_go = 1'b1;
            if (res_valid && n_res == 5 && !stalled) begin
                stalled    = 1'b1;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                res_ready = 1'b0;
                chk("stall_hold", 128'({res_valid, core_start, res_angle, res_cos}),
                    128'({1'b1, 1'b0, exp_angle, cos_of(exp_angle)}));
                stall_left--;
            end else begin
                res_ready = 1'b1;
            end
            if (res_valid && res_ready) begin
                chk($sformatf("result%0d", n_res), 128'({res_angle, res_cos, sample_cnt}),
                    128'({exp_angle, cos_of(exp_angle), 16'(n_res)}));
                last_angle = res_angle;
                exp_angle  = exp_angle + 18'(STEP);
                n_res++;
            end
            if (done) finished = 1'b1;
        end
        chk("sweep_finished", 128'(finished), 128'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (done) n_done++;
            if (core_start) n_start++;
        end
        chk("n_results", 128'(n_res), 128'(NRES));
        chk("last_angle", 128'(last_angle), 128'(LAST_ANG));
        chk("n_core_start", 128'(n_start), 128'(NRES));
        chk("n_done", 128'(n_done), 128'(1));
        chk("idle_hold", 128'({busy, res_valid, sample_cnt}), 128'({1'b0, 1'b0, 16'(NRES)}));

        // Reset during WAIT of angle 640, then a fresh sweep restarts at STEP.
        sweep_go = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            @(negedge clock);
            sweep_go = 1'b0;
            if (core_start && core_angle == 18'd640) seen = 1'b1;
        end
        chk("reach_640", 128'(seen), 128'(1));
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1 chk("reset_at_640", 128'(get_outs()), 128'(0));
        @(negedge clock) reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (core_start) seen = 1'b1;
        end
        chk("no_start_until_go", 128'(seen), 128'(0));
        sweep_go = 1'b1;
        @(negedge clock) sweep_go = 1'b0;
        chk("restart_at_step", 128'({core_start, core_angle, sample_cnt, busy}),
            128'({1'b1, 18'd64, 16'd0, 1'b1}));

        // Core that never answers.
        #2 reset = 1'b0;
        @(negedge clock);
        model_en = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        sweep_go = 1'b1;
        @(negedge clock) sweep_go = 1'b0;
        chk("to_start", 128'(core_start), 128'(1));
        repeat (256) @(negedge clock);
        chk("to_before", 128'({err, busy}), 128'({1'b0, 1'b1}));
        @(negedge clock);
`ifdef SWEEP_TIMEOUT_EN
        chk("to_expired", 128'({err, busy, res_valid}), 128'({1'b1, 1'b0, 1'b0}));
        sweep_go = 1'b1;
        @(negedge clock) sweep_go = 1'b0;
        chk("err_cleared", 128'({err, core_start}), 128'({1'b0, 1'b1}));
`else
        chk("wait_forever", 128'({err, busy, res_valid}), 128'({1'b0, 1'b1, 1'b0}));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
